// File: rtl/uart_msg_tx.sv
// uart_msg_tx: cell-to-host message serializer.
// Packed cell messages {i, j, status} are queued in a small FIFO. Each message
// is sent to the UART transmitter as a fixed byte frame: i, then j, then status.
// Each byte is handed over with a one-cycle send strobe, and the next byte waits
// for the transmitter's txdone pulse.
// Optional build macro: UART_MSG_TX_CHECKSUM_EN adds a fourth byte,
// byte0 ^ byte1 ^ byte2, to every frame.
module uart_msg_tx #(
    parameter int ADDR_WIDTH     = 4,
    parameter int BUFFER_SIZE    = 4,
    localparam int MESSAGE_WIDTH = 2 * (ADDR_WIDTH + 1) + 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [MESSAGE_WIDTH-1:0] txmessage,
    input  logic                     msg_valid,
    output logic                     msg_ready,
    output logic [7:0]               txdata,
    output logic                     send,
    input  logic                     txdone,
    output logic                     busy
);

    // Field and FIFO geometry
    localparam int COORD_W = ADDR_WIDTH + 1;
    localparam int PTR_W   = (BUFFER_SIZE > 1) ? $clog2(BUFFER_SIZE) : 1;
    localparam int CNT_W   = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH = CNT_W'(BUFFER_SIZE);

`ifdef UART_MSG_TX_CHECKSUM_EN
    localparam logic [1:0] LAST_IDX = 2'd3;
`else
    localparam logic [1:0] LAST_IDX = 2'd2;
`endif

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEND = 2'd1,
        S_WAIT = 2'd2
    } state_t;

    // FIFO storage and bookkeeping
    logic [MESSAGE_WIDTH-1:0] mem_q [BUFFER_SIZE];
    logic [MESSAGE_WIDTH-1:0] mem_d [BUFFER_SIZE];
    logic [PTR_W-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]         rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]         count_q, count_d;

    // Frame sequencer state
    state_t                   state_q, state_d;
    logic [1:0]               idx_q, idx_d;
    logic [MESSAGE_WIDTH-1:0] shadow_q, shadow_d;
    logic [7:0]               txdata_q, txdata_d;
    logic                     send_q, send_d;

    logic fifo_full;
    logic fifo_empty;
    logic do_push;
    logic do_pop;

    // Picks frame byte idx out of a packed message; each field is zero-extended.
    function automatic logic [7:0] frame_byte(input logic [MESSAGE_WIDTH-1:0] msg,
                                              input logic [1:0]               idx);
        logic [7:0] b_i;
        logic [7:0] b_j;
        logic [7:0] b_status;
        logic [7:0] result;
        b_i      = 8'(msg[MESSAGE_WIDTH-1 -: COORD_W]);
        b_j      = 8'(msg[4 +: COORD_W]);
        b_status = {4'b0000, msg[3:0]};
        case (idx)
            2'd0:    result = b_i;
            2'd1:    result = b_j;
            2'd2:    result = b_status;
`ifdef UART_MSG_TX_CHECKSUM_EN
            default: result = b_i ^ b_j ^ b_status;
`else
            default: result = 8'h00;
`endif
        endcase
        return result;
    endfunction

    assign fifo_full  = (count_q == DEPTH);
    assign fifo_empty = (count_q == '0);

    // A push needs room. The only pop is the one the idle sequencer takes to start a frame.
    assign do_push = msg_valid && !fifo_full;
    assign do_pop  = (state_q == S_IDLE) && !fifo_empty;

    // FIFO next state: write at the tail, advance the head on a pop, and track occupancy
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = txmessage;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Sequencer next state: strobe each frame byte once, then hold it until the UART reports it is done
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        shadow_d = shadow_q;
        txdata_d = txdata_q;
        send_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!fifo_empty) begin
                    shadow_d = mem_q[rd_ptr_q];
                    idx_d    = 2'd0;
                    txdata_d = frame_byte(mem_q[rd_ptr_q], 2'd0);
                    send_d   = 1'b1;
                    state_d  = S_SEND;
                end
            end
            S_SEND: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (txdone) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = S_IDLE;
                    end else begin
                        idx_d    = idx_q + 2'd1;
                        txdata_d = frame_byte(shadow_q, idx_q + 2'd1);
                        send_d   = 1'b1;
                        state_d  = S_SEND;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // All state registers. Reset abandons any in-flight frame and empties the FIFO.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < BUFFER_SIZE; k++) begin
                mem_q[k] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            state_q  <= S_IDLE;
            idx_q    <= 2'd0;
            shadow_q <= '0;
            txdata_q <= 8'h00;
            send_q   <= 1'b0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            state_q  <= state_d;
            idx_q    <= idx_d;
            shadow_q <= shadow_d;
            txdata_q <= txdata_d;
            send_q   <= send_d;
        end
    end

    assign msg_ready = !fifo_full;
    assign txdata    = txdata_q;
    assign send      = send_q;
    assign busy      = (state_q != S_IDLE) || !fifo_empty;

endmodule

// File: tb/tb_uart_msg_tx.sv
// Testbench for uart_msg_tx with default parameters (ADDR_WIDTH=4, BUFFER_SIZE=4).
// A queue-based reference model predicts send/txdata/msg_ready/busy each cycle.
// Directed scenarios also pin selected frame bytes to hand-computed literals.
module tb_uart_msg_tx;

   localparam int BUFFER_SIZE = 4;
`ifdef UART_MSG_TX_CHECKSUM_EN
   localparam int FRAME_LEN = 4;
`else
   localparam int FRAME_LEN = 3;
`endif

   localparam int PH_IDLE   = 0;
   localparam int PH_STROBE = 1;
   localparam int PH_AWAIT  = 2;

   logic        clk;
   logic        rst;
   logic [13:0] txmessage;
   logic        msgValid;
   logic        msgReady;
   logic [7:0]  txdata;
   logic        send;
   logic        txdone;
   logic        busy;
   logic        txdoneMan;
   logic        txdoneAuto;
   logic        autoAck;
   int          ackTimer;

   int checkCount;
   int errorCount;
   logic checkEn;

   // Reference model state
   logic [13:0] modelMsgQ[$];
   logic [7:0]  modelByteQ[$];
   int          modelPhase;
   logic        expSend;
   logic [7:0]  expTxdata;

   // Bytes the DUT actually strobed, for the per-scenario literal checks
   logic [7:0]  dutLog[$];

   uart_msg_tx dut (
      .clk       (clk),
      .rst       (rst),
      .txmessage (txmessage),
      .msg_valid (msgValid),
      .msg_ready (msgReady),
      .txdata    (txdata),
      .send      (send),
      .txdone    (txdone),
      .busy      (busy)
   );

   assign txdone = txdoneMan | txdoneAuto;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Pack a message the same way the cell array does: i in the MSBs, then j, then status
   function automatic logic [13:0] mkMsg(input int i, input int j, input int s);
      logic [4:0] fi;
      logic [4:0] fj;
      logic [3:0] fs;
      fi = 5'(i);
      fj = 5'(j);
      fs = 4'(s);
      return {fi, fj, fs};
   endfunction

   // Count one comparison, and report it if it fails
   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checkCount++;
      if (actual !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
      end
   endtask

   // Drive all inputs for one full cycle, starting at a falling edge and ending at the next one
   task automatic applyStimulus(input logic valid, input logic [13:0] msg, input logic done, input logic doReset);
      msgValid  = valid;
      txmessage = msg;
      txdoneMan = done;
      rst       = doReset;
      @(negedge clk);
   endtask

   task automatic idleCycles(input int n);
      for (int k = 0; k < n; k++) applyStimulus(1'b0, 14'd0, 1'b0, 1'b0);
   endtask

   // Let the DUT drain its queue and finish the current frame, with a bounded number of cycles
   task automatic waitIdle(input string name, input int maxCycles);
      int n;
      n = 0;
      while ((busy !== 1'b0 || ackTimer != 0) && n < maxCycles) begin
         applyStimulus(1'b0, 14'd0, 1'b0, 1'b0);
         n++;
      end
      checkOutput(name, {31'd0, busy}, 32'd0);
   endtask

   // Automatic UART stand-in: raise txdone for one cycle, four cycles after each send strobe
   always @(negedge clk) begin
      if (autoAck) begin
         txdoneAuto = 1'b0;
         if (ackTimer > 0) begin
            ackTimer--;
            if (ackTimer == 0) txdoneAuto = 1'b1;
         end
         if (send === 1'b1) ackTimer = 4;
      end else begin
         txdoneAuto = 1'b0;
         ackTimer   = 0;
      end
   end

   // Reference model, stepped on each rising edge using the inputs that were stable before it.
   // The pending messages form one queue; the frame being sent is a queue of bytes still to go.
   always @(posedge clk) begin
      logic [13:0] head;
      logic [7:0]  b0;
      logic [7:0]  b1;
      logic [7:0]  b2;
      logic        accept;
      if (rst) begin
         modelMsgQ.delete();
         modelByteQ.delete();
         modelPhase = PH_IDLE;
         expSend    = 1'b0;
         expTxdata  = 8'h00;
      end else begin
         accept  = msgValid && (modelMsgQ.size() < BUFFER_SIZE);
         expSend = 1'b0;
         if (modelPhase == PH_STROBE) begin
            modelPhase = PH_AWAIT;
         end else if (modelPhase == PH_AWAIT) begin
            if (txdone) begin
               if (modelByteQ.size() == 0) begin
                  modelPhase = PH_IDLE;
               end else begin
                  expTxdata  = modelByteQ.pop_front();
                  expSend    = 1'b1;
                  modelPhase = PH_STROBE;
               end
            end
         end else if (modelMsgQ.size() != 0) begin
            head = modelMsgQ.pop_front();
            b0   = {3'b000, head[13:9]};
            b1   = {3'b000, head[8:4]};
            b2   = {4'b0000, head[3:0]};
            modelByteQ.push_back(b0);
            modelByteQ.push_back(b1);
            modelByteQ.push_back(b2);
`ifdef UART_MSG_TX_CHECKSUM_EN
            modelByteQ.push_back(b0 ^ b1 ^ b2);
`endif
            expTxdata  = modelByteQ.pop_front();
            expSend    = 1'b1;
            modelPhase = PH_STROBE;
         end
         if (accept) modelMsgQ.push_back(txmessage);
      end
   end

   // Compare the DUT against the model on every falling edge, and log every strobed byte
   always @(negedge clk) begin
      if (checkEn) begin
         checkOutput("send", {31'd0, send}, {31'd0, expSend});
         checkOutput("txdata", {24'd0, txdata}, {24'd0, expTxdata});
         checkOutput("msg_ready", {31'd0, msgReady}, {31'd0, 1'(modelMsgQ.size() < BUFFER_SIZE)});
         checkOutput("busy", {31'd0, busy}, {31'd0, 1'(modelPhase != PH_IDLE || modelMsgQ.size() != 0)});
         if (send === 1'b1) dutLog.push_back(txdata);
      end
   end

   // Global watchdog, so the run can never hang
   initial begin
      #400000;
      $display("[TB] FAIL watchdog: simulation did not complete, got timeout, expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   // Directed scenarios
   initial begin
      logic [7:0] lit[4];
      int         pushed;
      int         guard;

      checkCount = 0;
      errorCount = 0;
      checkEn    = 1'b0;
      autoAck    = 1'b0;
      txdoneMan  = 1'b0;
      txdoneAuto = 1'b0;
      ackTimer   = 0;
      msgValid   = 1'b0;
      txmessage  = 14'd0;
      rst        = 1'b1;
      modelPhase = PH_IDLE;
      expSend    = 1'b0;
      expTxdata  = 8'h00;
      @(negedge clk);
      applyStimulus(1'b0, 14'd0, 1'b0, 1'b1);
      applyStimulus(1'b0, 14'd0, 1'b0, 1'b1);
      checkOutput("reset_send", {31'd0, send}, 32'd0);
      checkOutput("reset_txdata", {24'd0, txdata}, 32'h00);
      checkOutput("reset_ready", {31'd0, msgReady}, 32'd1);
      checkOutput("reset_busy", {31'd0, busy}, 32'd0);
      checkEn = 1'b1;

      // 1. Single frame i=5, j=10, status=3, each byte acknowledged four cycles later
      $display("[TB] scenario 1: single frame");
      dutLog.delete();
      autoAck = 1'b1;
      applyStimulus(1'b1, 14'b00101_01010_0011, 1'b0, 1'b0);
      applyStimulus(1'b0, 14'd0, 1'b0, 1'b0);
      checkOutput("latency_send", {31'd0, send}, 32'd1);
      checkOutput("latency_txdata", {24'd0, txdata}, 32'h05);
      waitIdle("single_drain", 200);
      lit[0] = 8'h05; lit[1] = 8'h0A; lit[2] = 8'h03; lit[3] = 8'h0C;
      checkOutput("single_len", dutLog.size(), FRAME_LEN);
      for (int k = 0; k < FRAME_LEN; k++) begin
         if (k < dutLog.size()) checkOutput($sformatf("single_byte%0d", k), {24'd0, dutLog[k]}, {24'd0, lit[k]});
      end

      // 2. Fill and stall: the fifth accept fills the FIFO and the sixth message is dropped
      $display("[TB] scenario 2: fill and stall");
      dutLog.delete();
      autoAck = 1'b0;
      idleCycles(1);
      for (int k = 1; k <= 5; k++) applyStimulus(1'b1, mkMsg(k, 20 + k, k), 1'b0, 1'b0);
      checkOutput("stall_ready_low", {31'd0, msgReady}, 32'd0);
      applyStimulus(1'b1, mkMsg(6, 26, 6), 1'b0, 1'b0);
      checkOutput("stall_ready_still_low", {31'd0, msgReady}, 32'd0);
      idleCycles(3);
      checkOutput("stall_one_send", dutLog.size(), 1);
      autoAck = 1'b1;
      applyStimulus(1'b0, 14'd0, 1'b1, 1'b0);
      waitIdle("stall_drain", 800);
      checkOutput("stall_len", dutLog.size(), 5 * FRAME_LEN);
      for (int k = 0; k < 5; k++) begin
         if (k * FRAME_LEN + 2 < dutLog.size()) begin
            checkOutput($sformatf("stall_i%0d", k + 1), {24'd0, dutLog[k * FRAME_LEN]}, k + 1);
            checkOutput($sformatf("stall_status%0d", k + 1), {24'd0, dutLog[k * FRAME_LEN + 2]}, k + 1);
         end
      end

      // 3. Wrap-around: ten messages with status 0..9 pushed as fast as the FIFO accepts them
      $display("[TB] scenario 3: wrap-around");
      dutLog.delete();
      pushed = 0;
      guard  = 0;
      while (pushed < 10 && guard < 2000) begin
         if (msgReady === 1'b1) begin
            applyStimulus(1'b1, mkMsg(pushed + 1, 30 - pushed, pushed), 1'b0, 1'b0);
            pushed++;
         end else begin
            applyStimulus(1'b0, 14'd0, 1'b0, 1'b0);
         end
         guard++;
      end
      checkOutput("wrap_pushed", pushed, 10);
      waitIdle("wrap_drain", 2000);
      checkOutput("wrap_len", dutLog.size(), 10 * FRAME_LEN);
      for (int k = 0; k < 10; k++) begin
         if (k * FRAME_LEN + 2 < dutLog.size())
            checkOutput($sformatf("wrap_status%0d", k), {24'd0, dutLog[k * FRAME_LEN + 2]}, k);
      end

      // 4. Spurious txdone while idle and during the send cycle
      $display("[TB] scenario 4: spurious txdone");
      dutLog.delete();
      autoAck = 1'b0;
      idleCycles(1);
      applyStimulus(1'b0, 14'd0, 1'b1, 1'b0);
      applyStimulus(1'b0, 14'd0, 1'b1, 1'b0);
      checkOutput("spur_idle_send", {31'd0, send}, 32'd0);
      checkOutput("spur_idle_busy", {31'd0, busy}, 32'd0);
      applyStimulus(1'b1, mkMsg(3, 7, 14), 1'b0, 1'b0);
      applyStimulus(1'b0, 14'd0, 1'b0, 1'b0);
      checkOutput("spur_first_send", {31'd0, send}, 32'd1);
      checkOutput("spur_first_byte", {24'd0, txdata}, 32'h03);
      applyStimulus(1'b0, 14'd0, 1'b1, 1'b0);
      checkOutput("spur_after_send", {31'd0, send}, 32'd0);
      idleCycles(5);
      checkOutput("spur_no_extra_send", dutLog.size(), 1);
      checkOutput("spur_txdata_held", {24'd0, txdata}, 32'h03);
      autoAck = 1'b1;
      applyStimulus(1'b0, 14'd0, 1'b1, 1'b0);
      checkOutput("spur_advance_send", {31'd0, send}, 32'd1);
      checkOutput("spur_advance_byte", {24'd0, txdata}, 32'h07);
      waitIdle("spur_drain", 200);
      checkOutput("spur_len", dutLog.size(), FRAME_LEN);

      // 5. Reset while waiting after byte 1, with two messages still queued
      $display("[TB] scenario 5: reset mid-frame");
      dutLog.delete();
      autoAck = 1'b0;
      idleCycles(1);
      applyStimulus(1'b1, mkMsg(1, 2, 3), 1'b0, 1'b0);
      applyStimulus(1'b1, mkMsg(4, 5, 6), 1'b0, 1'b0);
      applyStimulus(1'b1, mkMsg(7, 8, 9), 1'b0, 1'b0);
      applyStimulus(1'b0, 14'd0, 1'b1, 1'b0);
      applyStimulus(1'b0, 14'd0, 1'b0, 1'b0);
      checkOutput("midrst_pre_len", dutLog.size(), 2);
      applyStimulus(1'b0, 14'd0, 1'b0, 1'b1);
      checkOutput("midrst_send", {31'd0, send}, 32'd0);
      checkOutput("midrst_txdata", {24'd0, txdata}, 32'h00);
      checkOutput("midrst_ready", {31'd0, msgReady}, 32'd1);
      checkOutput("midrst_busy", {31'd0, busy}, 32'd0);
      applyStimulus(1'b0, 14'd0, 1'b1, 1'b0);
      idleCycles(3);
      checkOutput("midrst_no_send", dutLog.size(), 2);
      checkOutput("midrst_still_idle", {31'd0, busy}, 32'd0);

      // 6. Simultaneous push and pop: one message waiting while idle, a new one pushed on the pop edge
      $display("[TB] scenario 6: simultaneous push and pop");
      dutLog.delete();
      autoAck = 1'b0;
      applyStimulus(1'b1, mkMsg(9, 9, 1), 1'b0, 1'b0);
      idleCycles(2);
      for (int k = 1; k < FRAME_LEN; k++) begin
         applyStimulus(1'b0, 14'd0, 1'b1, 1'b0);
         applyStimulus(1'b0, 14'd0, 1'b0, 1'b0);
      end
      applyStimulus(1'b1, mkMsg(10, 11, 2), 1'b0, 1'b0);
      applyStimulus(1'b0, 14'd0, 1'b1, 1'b0);
      checkOutput("simul_idle_pending", {31'd0, busy}, 32'd1);
      autoAck = 1'b1;
      applyStimulus(1'b1, mkMsg(12, 13, 3), 1'b0, 1'b0);
      checkOutput("simul_pop_send", {31'd0, send}, 32'd1);
      checkOutput("simul_pop_byte", {24'd0, txdata}, 32'h0A);
      checkOutput("simul_ready", {31'd0, msgReady}, 32'd1);
      waitIdle("simul_drain", 400);
      checkOutput("simul_len", dutLog.size(), 3 * FRAME_LEN);
      for (int k = 0; k < 3; k++) begin
         if (k * FRAME_LEN + 2 < dutLog.size())
            checkOutput($sformatf("simul_status%0d", k), {24'd0, dutLog[k * FRAME_LEN + 2]}, k + 1);
      end

      checkEn = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
      $finish;
   end

endmodule

// File: doc/uart_msg_tx.md
Name: uart_msg_tx

Overview:
- Cell-to-host direction of the board link. Accepts packed cell messages (row, column, status) from the cell array into a small FIFO.
- Serializes each message as a fixed byte frame to the UART transmitter: byte 0 = i, byte 1 = j, byte 2 = status.
- The frame format and byte order match the 3-byte frame the host-to-cell receive path decodes.

Parameters:
- ADDR_WIDTH, 4: cell coordinate width; the i and j fields are each ADDR_WIDTH+1 bits wide. ADDR_WIDTH+1 must be ≤ 8.
- BUFFER_SIZE, 4: FIFO depth in messages. Must be a power of two and ≥ 2.
- MESSAGE_WIDTH, 2*(ADDR_WIDTH+1)+4 (derived localparam): packed message width.

Ports:
- clk  input  1  system clock; all logic on rising edge
- rst  input  1  synchronous, active-high reset
- txmessage  input  MESSAGE_WIDTH  packed message, {i[ADDR_WIDTH:0], j[ADDR_WIDTH:0], status[3:0]}, i in the MSBs
- msg_valid  input  1  txmessage is valid this cycle
- msg_ready  output  1  FIFO can accept a message; equals !full
- txdata  output  8  byte to the UART transmitter
- send  output  1  one-cycle pulse: UART starts transmitting txdata
- txdone  input  1  one-cycle pulse from UART: current byte fully shifted out
- busy  output  1  high when the FSM is not IDLE or the FIFO is non-empty

Behaviour:
- Reset, applied at a clk edge while rst=1:
  - FIFO pointers and count cleared; msg_ready=1.
  - FSM goes to IDLE; send=0, txdata=8'h00, busy=0, byte index=0.
  - Applies in any state. An in-flight frame is abandoned and not resumed.
  - txdone is ignored while rst=1.
- FIFO write:
  - A message is pushed on an edge where msg_valid && msg_ready.
  - msg_valid while full is ignored; no overwrite, no error flag.
- FIFO read: a pop happens only on the IDLE→SEND transition. The popped head is latched into a shadow register.
- Push and pop on the same edge: both take effect and count is unchanged. When full, msg_ready=0, so a push cannot coincide with full.
- Pointers: log2(BUFFER_SIZE) bits, wrapping naturally. Count is log2(BUFFER_SIZE)+1 bits.
- FSM states and transitions:
  - IDLE: if FIFO non-empty, pop, set byte index=0, go to SEND. Otherwise stay.
  - SEND: send=1 for exactly this cycle; txdata=byte[index]. Go to WAIT.
  - WAIT: send=0; txdata held stable. On txdone: if index is the last byte, go to IDLE; else index+1 and go to SEND.
- Byte mapping: each field is zero-extended to 8 bits.
  - byte0 = {0, i}
  - byte1 = {0, j}
  - byte2 = {4'b0, status}
- Latency: a message pushed at edge e0 into an empty FIFO with the FSM in IDLE is popped at e1 (IDLE→SEND). send is therefore high in the cycle after e1.
- Back-to-back messages: between frames the FSM passes through exactly one IDLE cycle (WAIT→IDLE→SEND).
- A txdone pulse received in IDLE or SEND is ignored. Only txdone in WAIT advances the FSM.
- txdata keeps its last value in IDLE.

Optional Feature:
- Macro: UART_MSG_TX_CHECKSUM_EN.
- Defined: a 4-byte frame. byte3 = byte0 ^ byte1 ^ byte2 is sent after status, with the same SEND/WAIT handshake. The last byte index is 3.
- Undefined: a 3-byte frame; the last byte index is 2; no checksum logic is instantiated.

Test Plan:
1. Single frame. Reset, then push i=5, j=10, status=3 (txmessage=14'b00101_01010_0011), answering each send with txdone 4 cycles later.
   - Without the macro: send pulses with txdata 0x05, 0x0A, 0x03, then busy=0.
   - With the macro: a fourth pulse with txdata 0x0C.
2. Fill and stall. Hold txdone low; push 6 messages on consecutive cycles.
   - Messages 1–5 are accepted: 1 is popped immediately, then the FIFO holds 4.
   - msg_ready=0 after the fifth accept, and message 6 is dropped.
   - Releasing txdone delivers messages 1–5 in order.
3. Wrap-around. Push and drain 10 messages with distinct status 0..9 through a BUFFER_SIZE=4 FIFO.
   - Status bytes appear exactly as 0x00 through 0x09 in order, with no duplicates or losses.
4. Spurious txdone.
   - txdone pulses while IDLE and during the SEND cycle: no state change, no extra send.
   - Only a txdone in WAIT advances the frame.
5. Reset mid-frame. Assert rst for 1 cycle while in WAIT after byte1 with 2 messages queued.
   - Next cycle: send=0, txdata=0x00, msg_ready=1, busy=0.
   - A subsequent txdone produces no send.
6. Simultaneous push and pop. FIFO holds 1 message with the FSM in IDLE; push a new message on the same edge the FSM pops.
   - Count stays 1; both messages are transmitted in order.
